// File: rtl/pc_fetch_pkg.sv
// Shared state encoding and constants for the PC fetch sequencer.
package pc_fetch_pkg;

   typedef enum logic [1:0] {StBoot, StFetch, StIssue, StTrap} fetch_state_t;

   localparam logic [1:0]  CAUSE_MISALIGN = 2'd0;
   localparam logic [1:0]  CAUSE_TIMEOUT  = 2'd1;
   localparam logic [31:0] INSN_BYTES     = 32'd4;

endpackage

// File: rtl/fetch_wait_ctr.sv
// Saturating 8-bit counter of FETCH cycles spent waiting for an imem ack.
module fetch_wait_ctr #(
   parameter int unsigned MAX_WAIT = 15
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_clr,
   input  logic i_inc,
   output logic o_at_max
);

   localparam logic [7:0] MaxCnt = 8'(MAX_WAIT);

   logic [7:0] r_count;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count <= 8'd0;
      end else if (i_clr) begin
         r_count <= 8'd0;
      end else if (i_inc && (r_count != 8'hFF)) begin
         r_count <= r_count + 8'd1;
      end
   end

   assign o_at_max = (r_count == MaxCnt);

endmodule

// File: rtl/pc_fetch_ctrl.sv
// RV32I PC sequencer: drives the PC register, the imem req/ack port and the
// decode valid/ready port, and raises traps on misaligned targets or fetch timeouts.
module pc_fetch_ctrl
   import pc_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0010,
   parameter int unsigned MAX_WAIT     = 15
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [31:0] i_pc_q,
   input  logic        i_pc_valid,
   output logic [31:0] o_pc_d,
   output logic        o_pc_en,
   output logic        o_imem_req,
   output logic [31:0] o_imem_addr,
   input  logic        i_imem_ack,
   input  logic [31:0] i_imem_rdata,
   output logic [31:0] o_inst,
   output logic [31:0] o_inst_pc,
   output logic        o_inst_valid,
   input  logic        i_inst_ready,
   input  logic        i_redirect,
   input  logic [31:0] i_redirect_pc,
   output logic        o_trap,
   output logic [1:0]  o_trap_cause,
   output logic [31:0] o_trap_pc
);

   fetch_state_t r_state;
   logic [31:0]  r_inst;
   logic [31:0]  r_inst_pc;
   logic [1:0]   r_trap_cause;
   logic [31:0]  r_trap_pc;

   logic w_in_fetch;
   logic w_redir;
   logic w_misalign;
   logic w_redir_ok;
   logic w_at_max;
   logic w_timeout;
   logic w_take;

   assign w_in_fetch = (r_state == StFetch);
   // Redirects are only honoured while fetching or issuing.
   assign w_redir    = i_redirect & (w_in_fetch | (r_state == StIssue));
   assign w_misalign = w_redir & (i_redirect_pc[1:0] != 2'b00);
   assign w_redir_ok = w_redir & ~w_misalign;
   assign w_timeout  = w_in_fetch & w_at_max & ~w_redir;
   assign w_take     = w_in_fetch & i_imem_ack & ~w_redir & ~w_at_max;

   fetch_wait_ctr #(
      .MAX_WAIT (MAX_WAIT)
   ) u_wait_ctr (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_clr    (~w_in_fetch | w_redir),
      .i_inc    (w_in_fetch & ~i_imem_ack),
      .o_at_max (w_at_max)
   );

   // The PC register invalidates itself when not enabled, so hold is pc_d = pc_q.
   always_comb begin
      o_pc_d = i_pc_q;
      case (r_state)
         StBoot:  o_pc_d = RESET_VECTOR;
         StTrap:  o_pc_d = TRAP_VECTOR;
         default: begin
            if (w_redir_ok) begin
               o_pc_d = i_redirect_pc;
            end else if (w_take) begin
               o_pc_d = i_pc_q + INSN_BYTES;
            end
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= StBoot;
         r_inst       <= 32'd0;
         r_inst_pc    <= 32'd0;
         r_trap_cause <= CAUSE_MISALIGN;
         r_trap_pc    <= 32'd0;
      end else begin
         case (r_state)
            StBoot: r_state <= StFetch;
            StFetch, StIssue: begin
               if (w_misalign) begin
                  r_state      <= StTrap;
                  r_trap_cause <= CAUSE_MISALIGN;
                  r_trap_pc    <= i_redirect_pc;
               end else if (w_redir_ok) begin
                  r_state <= StFetch;
               end else if (w_timeout) begin
                  r_state      <= StTrap;
                  r_trap_cause <= CAUSE_TIMEOUT;
                  r_trap_pc    <= i_pc_q;
               end else if (w_take) begin
                  r_state   <= StIssue;
                  r_inst    <= i_imem_rdata;
                  r_inst_pc <= i_pc_q;
               end else if ((r_state == StIssue) && i_inst_ready) begin
                  r_state <= StFetch;
               end
            end
            StTrap: r_state <= StFetch;
         endcase
      end
   end

   assign o_pc_en      = 1'b1;
   assign o_imem_req   = w_in_fetch & i_pc_valid;
   assign o_imem_addr  = i_pc_q;
   assign o_inst       = r_inst;
   assign o_inst_pc    = r_inst_pc;
   assign o_inst_valid = (r_state == StIssue);
   assign o_trap       = (r_state == StTrap);
   assign o_trap_cause = r_trap_cause;
   assign o_trap_pc    = r_trap_pc;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed scenarios plus randomized fetch/issue/redirect
// transactions checked against a program-order model of the fetch stream.
module tb_pc_fetch_ctrl;

   localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
   localparam logic [31:0] TRAP_VECTOR  = 32'h0000_0010;
   localparam int unsigned MAX_WAIT     = 15;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] pc_q = 32'd0;
   logic        pc_valid = 1'b0;
   logic [31:0] pc_d;
   logic        pc_en;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = 32'd0;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_valid;
   logic        inst_ready = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'd0;
   logic        trap;
   logic [1:0]  trap_cause;
   logic [31:0] trap_pc;

   int          checks = 0;
   int          failures = 0;
   logic [31:0] m_pc = RESET_VECTOR;
   logic [31:0] last_inst = 32'd0;
   logic [31:0] last_pc = 32'd0;

   always #5 clk = ~clk;

   // External PC register: loads pc_d when enabled, invalid whenever disabled.
   always @(posedge clk) begin
      if (pc_en) pc_q <= pc_d;
      pc_valid <= pc_en;
   end

   pc_fetch_ctrl #(
      .RESET_VECTOR (RESET_VECTOR),
      .TRAP_VECTOR  (TRAP_VECTOR),
      .MAX_WAIT     (MAX_WAIT)
   ) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_pc_q        (pc_q),
      .i_pc_valid    (pc_valid),
      .o_pc_d        (pc_d),
      .o_pc_en       (pc_en),
      .o_imem_req    (imem_req),
      .o_imem_addr   (imem_addr),
      .i_imem_ack    (imem_ack),
      .i_imem_rdata  (imem_rdata),
      .o_inst        (inst),
      .o_inst_pc     (inst_pc),
      .o_inst_valid  (inst_valid),
      .i_inst_ready  (inst_ready),
      .i_redirect    (redirect),
      .i_redirect_pc (redirect_pc),
      .o_trap        (trap),
      .o_trap_cause  (trap_cause),
      .o_trap_pc     (trap_pc)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One fetch: wt wait cycles, ack, then rd cycles in issue before the final issue cycle.
   // kind 0: plain; 1: aligned redirect on final issue cycle; 2: misaligned redirect there.
   task automatic run_txn(input int unsigned wt, input int unsigned rd, input int unsigned kind,
                          input logic [31:0] tgt, input string tag);
      logic [31:0] word;
      logic [31:0] exp_pcd;
      word = $urandom;
      for (int k = 0; k < int'(wt); k++) begin
         imem_ack = 1'b0;
         @(negedge clk);
         checks++;
         if (imem_req !== 1'b1 || imem_addr !== m_pc || pc_d !== m_pc || trap !== 1'b0) begin
            failures++;
            $display("FAIL %s_wait req=%b addr=%h pc_d=%h trap=%b want req=1 addr=%h pc_d=%h trap=0",
                     tag, imem_req, imem_addr, pc_d, trap, m_pc, m_pc);
         end
         step();
      end
      imem_ack = 1'b1;
      imem_rdata = word;
      @(negedge clk);
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== m_pc || pc_d !== m_pc + 32'd4 || pc_en !== 1'b1) begin
         failures++;
         $display("FAIL %s_ack req=%b addr=%h pc_d=%h en=%b want req=1 addr=%h pc_d=%h en=1",
                  tag, imem_req, imem_addr, pc_d, pc_en, m_pc, m_pc + 32'd4);
      end
      step();
      imem_ack = 1'b0;
      last_inst = word;
      last_pc = m_pc;
      for (int j = 0; j <= int'(rd); j++) begin
         if (j == int'(rd)) begin
            inst_ready = (kind == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            redirect = (kind != 0);
         end else begin
            inst_ready = 1'b0;
            redirect = 1'b0;
         end
         redirect_pc = tgt;
         exp_pcd = (redirect && kind == 1) ? tgt : m_pc + 32'd4;
         @(negedge clk);
         checks++;
         if (inst_valid !== 1'b1 || inst !== word || inst_pc !== m_pc || imem_req !== 1'b0 ||
             pc_d !== exp_pcd) begin
            failures++;
            $display("FAIL %s_issue v=%b inst=%h ipc=%h req=%b pc_d=%h want v=1 inst=%h ipc=%h req=0 pc_d=%h",
                     tag, inst_valid, inst, inst_pc, imem_req, pc_d, word, m_pc, exp_pcd);
         end
         step();
      end
      inst_ready = 1'b0;
      redirect = 1'b0;
      if (kind == 2) begin
         @(negedge clk);
         checks++;
         if (trap !== 1'b1 || trap_cause !== 2'd0 || trap_pc !== tgt || pc_d !== TRAP_VECTOR ||
             inst_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s_trap trap=%b cause=%0d tpc=%h pc_d=%h v=%b want 1 0 %h %h 0",
                     tag, trap, trap_cause, trap_pc, pc_d, inst_valid, tgt, TRAP_VECTOR);
         end
         step();
         m_pc = TRAP_VECTOR;
      end else if (kind == 1) begin
         m_pc = tgt;
      end else begin
         m_pc = m_pc + 32'd4;
      end
   endtask

   task automatic test_reset();
      #3;
      checks++;
      if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%b want=0", imem_req); end
      checks++;
      if (inst_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b want=0", inst_valid); end
      checks++;
      if (inst !== 32'd0 || inst_pc !== 32'd0) begin
         failures++; $display("FAIL rst_inst got=%h/%h want=0/0", inst, inst_pc);
      end
      checks++;
      if (trap !== 1'b0 || trap_cause !== 2'd0 || trap_pc !== 32'd0) begin
         failures++; $display("FAIL rst_trap got=%b/%0d/%h want=0/0/0", trap, trap_cause, trap_pc);
      end
      checks++;
      if (pc_en !== 1'b1 || pc_d !== RESET_VECTOR) begin
         failures++; $display("FAIL rst_pc got en=%b pc_d=%h want en=1 pc_d=%h", pc_en, pc_d, RESET_VECTOR);
      end
      step();
      step();
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (imem_req !== 1'b0 || pc_d !== RESET_VECTOR || pc_en !== 1'b1 || inst_valid !== 1'b0) begin
         failures++;
         $display("FAIL boot got req=%b pc_d=%h en=%b v=%b want 0 %h 1 0", imem_req, pc_d, pc_en,
                  inst_valid, RESET_VECTOR);
      end
      step();
      m_pc = RESET_VECTOR;
   endtask

   task automatic test_stream();
      run_txn(0, 0, 0, 32'd0, "stream0");
      run_txn(0, 0, 0, 32'd0, "stream1");
   endtask

   task automatic test_timeout();
      for (int c = 0; c < int'(MAX_WAIT); c++) begin
         imem_ack = 1'b0;
         @(negedge clk);
         checks++;
         if (imem_req !== 1'b1 || imem_addr !== m_pc || pc_d !== m_pc || trap !== 1'b0) begin
            failures++;
            $display("FAIL tmo_wait%0d req=%b addr=%h pc_d=%h trap=%b want 1 %h %h 0", c, imem_req,
                     imem_addr, pc_d, trap, m_pc, m_pc);
         end
         step();
      end
      // A late ack loses to the timeout.
      imem_ack = 1'b1;
      imem_rdata = 32'hBAD0_BAD0;
      @(negedge clk);
      checks++;
      if (pc_d !== m_pc) begin
         failures++; $display("FAIL tmo_late_ack pc_d=%h want=%h", pc_d, m_pc);
      end
      step();
      imem_ack = 1'b0;
      @(negedge clk);
      checks++;
      if (trap !== 1'b1 || trap_cause !== 2'd1 || trap_pc !== m_pc || pc_d !== TRAP_VECTOR ||
          imem_req !== 1'b0 || inst_valid !== 1'b0 || inst_pc !== last_pc) begin
         failures++;
         $display("FAIL tmo_trap trap=%b cause=%0d tpc=%h pc_d=%h req=%b v=%b ipc=%h want 1 1 %h %h 0 0 %h",
                  trap, trap_cause, trap_pc, pc_d, imem_req, inst_valid, inst_pc, m_pc, TRAP_VECTOR,
                  last_pc);
      end
      step();
      m_pc = TRAP_VECTOR;
      @(negedge clk);
      checks++;
      if (trap !== 1'b0 || imem_addr !== m_pc || imem_req !== 1'b1) begin
         failures++; $display("FAIL tmo_refetch trap=%b addr=%h req=%b want 0 %h 1", trap, imem_addr,
                              imem_req, m_pc);
      end
      step();
   endtask

   task automatic test_redirect_issue();
      imem_ack = 1'b1;
      imem_rdata = 32'hDEAD_0010;
      step();
      imem_ack = 1'b0;
      last_inst = 32'hDEAD_0010;
      last_pc = m_pc;
      inst_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== last_pc || inst !== last_inst) begin
         failures++; $display("FAIL rdi_issue v=%b ipc=%h inst=%h want 1 %h %h", inst_valid, inst_pc,
                              inst, last_pc, last_inst);
      end
      step();
      redirect = 1'b1;
      redirect_pc = 32'h0000_0100;
      @(negedge clk);
      checks++;
      if (pc_d !== 32'h0000_0100) begin
         failures++; $display("FAIL rdi_pc_d got=%h want=00000100", pc_d);
      end
      step();
      redirect = 1'b0;
      m_pc = 32'h0000_0100;
      @(negedge clk);
      checks++;
      if (inst_valid !== 1'b0 || imem_addr !== m_pc || imem_req !== 1'b1) begin
         failures++; $display("FAIL rdi_refetch v=%b addr=%h req=%b want 0 %h 1", inst_valid,
                              imem_addr, imem_req, m_pc);
      end
      step();
   endtask

   task automatic test_misalign();
      redirect = 1'b1;
      redirect_pc = 32'h0000_0102;
      @(negedge clk);
      checks++;
      if (pc_d !== m_pc) begin
         failures++; $display("FAIL mis_hold pc_d=%h want=%h", pc_d, m_pc);
      end
      step();
      redirect = 1'b0;
      @(negedge clk);
      checks++;
      if (trap !== 1'b1 || trap_cause !== 2'd0 || trap_pc !== 32'h0000_0102 || pc_d !== TRAP_VECTOR) begin
         failures++; $display("FAIL mis_trap trap=%b cause=%0d tpc=%h pc_d=%h want 1 0 00000102 %h",
                              trap, trap_cause, trap_pc, pc_d, TRAP_VECTOR);
      end
      step();
      m_pc = TRAP_VECTOR;
      @(negedge clk);
      checks++;
      if (trap !== 1'b0 || imem_addr !== m_pc) begin
         failures++; $display("FAIL mis_refetch trap=%b addr=%h want 0 %h", trap, imem_addr, m_pc);
      end
      step();
   endtask

   task automatic test_redirect_ack();
      imem_ack = 1'b1;
      imem_rdata = 32'h1111_2222;
      redirect = 1'b1;
      redirect_pc = 32'h0000_0040;
      @(negedge clk);
      checks++;
      if (pc_d !== 32'h0000_0040) begin
         failures++; $display("FAIL rda_pc_d got=%h want=00000040", pc_d);
      end
      step();
      imem_ack = 1'b0;
      redirect = 1'b0;
      m_pc = 32'h0000_0040;
      @(negedge clk);
      checks++;
      if (inst_valid !== 1'b0 || imem_addr !== m_pc || inst !== last_inst || inst_pc !== last_pc) begin
         failures++; $display("FAIL rda_discard v=%b addr=%h inst=%h ipc=%h want 0 %h %h %h", inst_valid,
                              imem_addr, inst, inst_pc, m_pc, last_inst, last_pc);
      end
      step();
   endtask

   task automatic test_wrap();
      redirect = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      @(negedge clk);
      checks++;
      if (pc_d !== 32'hFFFF_FFFC) begin
         failures++; $display("FAIL wrap_redir pc_d=%h want=fffffffc", pc_d);
      end
      step();
      redirect = 1'b0;
      m_pc = 32'hFFFF_FFFC;
      run_txn(0, 0, 0, 32'd0, "wrap");
      @(negedge clk);
      checks++;
      if (imem_addr !== 32'd0 || imem_req !== 1'b1) begin
         failures++; $display("FAIL wrap_addr addr=%h req=%b want 00000000 1", imem_addr, imem_req);
      end
      step();
   endtask

   task automatic test_random();
      int unsigned sel;
      int unsigned kind;
      logic [31:0] r;
      logic [31:0] tgt;
      for (int n = 0; n < 40; n++) begin
         sel = $urandom_range(0, 5);
         kind = (sel == 4) ? 1 : (sel == 5) ? 2 : 0;
         r = $urandom;
         tgt = r & 32'hFFFF_FFFC;
         if (kind == 2) tgt = tgt | 32'($urandom_range(1, 3));
         run_txn($urandom_range(0, 6), $urandom_range(0, 3), kind, tgt, "rand");
      end
   endtask

   task automatic test_reset_mid();
      imem_ack = 1'b1;
      imem_rdata = 32'hCAFE_F00D;
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({imem_req, inst_valid, inst, inst_pc, trap, trap_cause, trap_pc, pc_en, pc_d} !==
          {1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 2'd0, 32'd0, 1'b1, RESET_VECTOR}) begin
         failures++;
         $display("FAIL midrst req=%b v=%b inst=%h ipc=%h trap=%b cause=%0d tpc=%h en=%b pc_d=%h",
                  imem_req, inst_valid, inst, inst_pc, trap, trap_cause, trap_pc, pc_en, pc_d);
      end
      step();
      step();
      imem_ack = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (imem_req !== 1'b0 || pc_d !== RESET_VECTOR || inst_valid !== 1'b0 || inst !== 32'd0) begin
         failures++; $display("FAIL midrst_boot req=%b pc_d=%h v=%b inst=%h want 0 %h 0 0", imem_req,
                              pc_d, inst_valid, inst, RESET_VECTOR);
      end
      step();
      @(negedge clk);
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== RESET_VECTOR) begin
         failures++; $display("FAIL midrst_fetch req=%b addr=%h want 1 %h", imem_req, imem_addr,
                              RESET_VECTOR);
      end
      step();
   endtask

   initial begin
      test_reset();
      test_stream();
      test_timeout();
      test_redirect_issue();
      test_misalign();
      test_redirect_ack();
      test_wrap();
      test_random();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
Sequencer for the RV32I program counter register and the instruction-fetch port.
- Decides every cycle what the PC register loads: boot vector, PC+4, a branch/jump target, the trap vector, or its own value (hold).
- Runs a req/ack handshake to instruction memory and a valid/ready handshake to decode.
- Raises a trap on a misaligned target or a fetch timeout.
- Sits between the execute stage's redirect outputs, the PC register, imem and decode.

Parameters:
RESET_VECTOR, 32'h0000_0000, first fetch address after reset.
TRAP_VECTOR, 32'h0000_0010, PC loaded on any fetch trap.
MAX_WAIT, 15, cycles in FETCH without imem_ack before a timeout trap (1..255).

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
pc_q  in  32  current PC from PC register
pc_valid  in  1  PC register valid flag
pc_d  out  32  next PC to PC register
pc_en  out  1  PC register load enable
imem_req  out  1  fetch request
imem_addr  out  32  fetch address (always pc_q)
imem_ack  in  1  single-cycle ack; imem_rdata valid this cycle
imem_rdata  in  32  fetched word
inst  out  32  instruction to decode
inst_pc  out  32  PC of inst
inst_valid  out  1  inst/inst_pc valid
inst_ready  in  1  decode accepts
redirect  in  1  branch/jump taken (single-cycle pulse)
redirect_pc  in  32  target address
trap  out  1  single-cycle trap pulse
trap_cause  out  2  0 = misaligned target, 1 = fetch timeout
trap_pc  out  32  offending address

Behaviour:
- Reset (rst=0, async): state=BOOT; wait counter=0.
  - Output values during reset: imem_req=0, inst_valid=0, inst=0, inst_pc=0, trap=0, trap_cause=0, trap_pc=0, pc_en=1, pc_d=RESET_VECTOR.
- PC register rule: the register invalidates its contents whenever en=0.
  - pc_en is therefore 1 in every state after reset.
  - Hold is implemented as pc_d=pc_q, never by dropping pc_en.
- States:
  - BOOT:
    - pc_d=RESET_VECTOR.
    - Next: FETCH, unconditionally.
  - FETCH:
    - imem_req = pc_valid; imem_addr=pc_q.
    - On a cycle with imem_ack & ~redirect:
      - latch inst<=imem_rdata and inst_pc<=pc_q;
      - pc_d=pc_q+4 (mod 2^32; wrap 0xFFFF_FFFC -> 0 is legal);
      - next: ISSUE.
    - Otherwise: pc_d=pc_q; wait counter increments.
    - Counter reaching MAX_WAIT: go to TRAP, cause 1, trap_pc=pc_q.
  - ISSUE:
    - inst_valid=1; pc_d=pc_q.
    - On inst_ready: next FETCH, with the counter cleared.
  - TRAP:
    - trap=1 for exactly one cycle; pc_d=TRAP_VECTOR.
    - Next: FETCH with the counter cleared.
    - inst_valid=0 and imem_req=0 in TRAP.
- Redirect rules (any state except BOOT and TRAP; in BOOT/TRAP redirect is ignored):
  - redirect_pc[1:0]≠0: go to TRAP, cause 0, trap_pc=redirect_pc; pc_d=pc_q this cycle.
  - Aligned target: pc_d=redirect_pc; next FETCH; counter cleared.
  - Redirect with imem_ack in the same cycle: the fetched word is discarded, no latch.
  - Redirect in ISSUE without inst_ready: the instruction is dropped and inst_valid falls next cycle.
  - Redirect in ISSUE with inst_ready: the handshake completes (instruction consumed) and the redirect is still applied.
- Priority per cycle: misaligned redirect > aligned redirect > timeout > ack.
- imem_req never drops while in FETCH unless redirect, timeout or pc_valid=0 occurs.
- Latency:
  - Reset release to first imem_req: 1 cycle (BOOT).
  - Ack to inst_valid: 1 cycle.
  - Steady throughput: 1 instruction per 2 cycles with zero-wait imem and ready decode.
- Reset asserted mid-operation: immediate return to the reset values above; an in-flight ack is ignored.

Decomposition:
- Package pc_fetch_pkg holds:
  - state encoding (BOOT, FETCH, ISSUE, TRAP);
  - trap cause codes CAUSE_MISALIGN=2'd0 and CAUSE_TIMEOUT=2'd1;
  - INSN_BYTES=4.
- One sub-module: fetch_wait_ctr. It is an 8-bit saturating counter with clear/inc inputs and an at_max output compared against MAX_WAIT, using the same clk/rst.

Test Plan:
- Release reset, imem acks in the cycle of each req, inst_ready tied 1:
  - imem_addr sequence 0x0, 0x4, 0x8 on every other cycle;
  - inst_pc matches imem_addr; pc_en=1 throughout.
- Hold imem_ack=0 for 15 cycles in FETCH at PC 0x8:
  - trap=1 for one cycle, trap_cause=1, trap_pc=0x8;
  - next imem_addr=0x10.
- In ISSUE with inst_ready=0, pulse redirect with redirect_pc=0x100:
  - inst_valid drops; next imem_addr=0x100; the old instruction is never accepted.
- Pulse redirect with redirect_pc=0x102:
  - trap_cause=0, trap_pc=0x102, then fetch from 0x10.
- Redirect to 0x40 in the same cycle as imem_ack:
  - no inst_valid for the discarded word; next fetch is 0x40.
- Start at pc_q=0xFFFF_FFFC, ack:
  - pc_d=0x0, then next fetch address 0x0.
- Assert rst mid-FETCH:
  - all outputs take their reset values asynchronously;
  - after release, BOOT then fetch from RESET_VECTOR.
